// File: rtl/line_gen_pkg.sv
// Shared definitions for the playfield line generator.
//   - MODE_* : request mode encodings carried on mode_i
//   - state_e: generator FSM states
//   - lfsr_taps(): Galois (right-shifting) tap mask for a given LFSR width
package line_gen_pkg;

  localparam logic [1:0] MODE_SOLID     = 2'b00;
  localparam logic [1:0] MODE_NOISE     = 2'b01;
  localparam logic [1:0] MODE_GAP       = 2'b10;
  localparam logic [1:0] MODE_NOISE_GAP = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StDraw,
    StFill
  } state_e;

  // Maximal-length tap masks; bit i set means state bit i is toggled when a 1 shifts out.
  function automatic logic [63:0] lfsr_taps(input int unsigned width);
    logic [63:0] taps;
    case (width)
      8:       taps = 64'h0000_0000_0000_00B8;
      16:      taps = 64'h0000_0000_0000_B400;
      24:      taps = 64'h0000_0000_00E1_0000;
      32:      taps = 64'h0000_0000_A300_0000;
      default: taps = 64'h0000_0000_0000_B400;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/lfsr_gal.sv
// Free-running Galois LFSR, right-shifting.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset, loads the seed (0 is replaced by 1)
//   en_i    : advance one step this cycle
//   state_o : full LFSR state
module lfsr_gal
  import line_gen_pkg::*;
#(
  parameter int unsigned          LfsrWidth = 16,
  parameter logic [LfsrWidth-1:0] Seed      = 16'hACE1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  output logic [LfsrWidth-1:0] state_o
);

  localparam logic [LfsrWidth-1:0] Taps    = LfsrWidth'(lfsr_taps(LfsrWidth));
  // An all-zero state would lock up the register.
  localparam logic [LfsrWidth-1:0] SeedEff = (Seed == '0) ? LfsrWidth'(1) : Seed;

  logic [LfsrWidth-1:0] state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SeedEff;
    end else if (en_i) begin
      state_q <= (state_q >> 1) ^ (state_q[0] ? Taps : '0);
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/gen_line_gap.sv
// Line generator for the scrolling-obstacle playfield.
// Produces one Width-bit line per request: solid, LFSR noise, solid with a random gap,
// or noise with a guaranteed gap, and reports the gap position.
//   clk_i     : sole clock
//   rst_i     : synchronous active-high reset
//   req_i     : request a new line (sampled only when idle)
//   mode_i    : MODE_SOLID / MODE_NOISE / MODE_GAP / MODE_NOISE_GAP, latched with req_i
//   busy_o    : generator is working on a line
//   valid_o   : one-cycle pulse when line_o first holds the new line
//   line_o    : current line, 1 = wall, 0 = open
//   gap_pos_o : lowest gap bit index, 0 for modes without a gap
module gen_line_gap
  import line_gen_pkg::*;
#(
  parameter int unsigned          Width        = 640,
  parameter int unsigned          GapWidth     = 80,
  parameter int unsigned          BitsPerCycle = 8,
  parameter int unsigned          LfsrWidth    = 16,
  parameter logic [LfsrWidth-1:0] Seed         = 16'hACE1,
  parameter int unsigned          MaxTries     = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_i,
  input  logic [1:0]               mode_i,
  output logic                     busy_o,
  output logic                     valid_o,
  output logic [Width-1:0]         line_o,
  output logic [$clog2(Width)-1:0] gap_pos_o
);

  localparam int unsigned PosW   = $clog2(Width);
  localparam int unsigned Fills  = Width / BitsPerCycle;
  localparam int unsigned FillW  = (Fills > 1) ? $clog2(Fills) : 1;
  localparam int unsigned TryW   = (MaxTries > 1) ? $clog2(MaxTries) : 1;
  localparam int unsigned MaxPos = Width - GapWidth;

  logic [LfsrWidth-1:0] lfsr;
  state_e               state_q;
  logic [1:0]           mode_q;
  logic [Width-1:0]     work_q;
  logic [PosW-1:0]      pos_q;
  logic [TryW-1:0]      try_q;
  logic [FillW-1:0]     fill_q;

  logic [PosW-1:0]  cand;
  logic             cand_ok;
  logic             forced;
  logic [PosW-1:0]  pos_sel;
  logic [Width-1:0] gap_mask;
  logic [Width-1:0] fill_word;
  logic             unused_lfsr;

  lfsr_gal #(
    .LfsrWidth (LfsrWidth),
    .Seed      (Seed)
  ) u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (1'b1),
    .state_o (lfsr)
  );

  // Only the low bits feed candidates and noise.
  assign unused_lfsr = ^lfsr;

  assign cand    = lfsr[PosW-1:0];
  assign cand_ok = 32'(cand) <= MaxPos;
  // Last allowed draw also failed: fall back to the rightmost legal position.
  assign forced  = !cand_ok && (try_q == TryW'(MaxTries - 1));

  // In DRAW the position is being decided this edge, so the mask must use it directly.
  always_comb begin
    pos_sel = pos_q;
    if (state_q == StDraw) begin
      pos_sel = forced ? PosW'(MaxPos) : cand;
    end
  end

  always_comb begin
    gap_mask = '1;
    for (int i = 0; i < int'(Width); i++) begin
      if (i >= int'(pos_sel) && i < int'(pos_sel) + int'(GapWidth)) begin
        gap_mask[i] = 1'b0;
      end
    end
  end

  // New noise enters at the top; the first chunk drawn ends up in the lowest bits.
  assign fill_word = (work_q >> BitsPerCycle) |
                     (Width'(lfsr[BitsPerCycle-1:0]) << (Width - BitsPerCycle));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      mode_q    <= MODE_SOLID;
      work_q    <= '1;
      pos_q     <= '0;
      try_q     <= '0;
      fill_q    <= '0;
      line_o    <= '1;
      gap_pos_o <= '0;
      valid_o   <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_i) begin
            mode_q <= mode_i;
            work_q <= '1;
            try_q  <= '0;
            fill_q <= '0;
            pos_q  <= '0;
            unique case (mode_i)
              MODE_SOLID: begin
                line_o    <= '1;
                gap_pos_o <= '0;
                valid_o   <= 1'b1;
              end
              MODE_NOISE: begin
                state_q <= StFill;
                busy_o  <= 1'b1;
              end
              default: begin
                state_q <= StDraw;
                busy_o  <= 1'b1;
              end
            endcase
          end
        end
        StDraw: begin
          if (cand_ok || forced) begin
            pos_q <= pos_sel;
            if (mode_q == MODE_GAP) begin
              line_o    <= gap_mask;
              gap_pos_o <= pos_sel;
              valid_o   <= 1'b1;
              busy_o    <= 1'b0;
              state_q   <= StIdle;
            end else begin
              state_q <= StFill;
            end
          end else begin
            try_q <= try_q + 1'b1;
          end
        end
        StFill: begin
          work_q <= fill_word;
          fill_q <= fill_q + 1'b1;
          if (fill_q == FillW'(Fills - 1)) begin
            line_o    <= mode_q[1] ? (fill_word & gap_mask) : fill_word;
            gap_pos_o <= mode_q[1] ? pos_q : '0;
            valid_o   <= 1'b1;
            busy_o    <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gen_line_gap.sv
// Self-checking bench for gen_line_gap: two instances (GapWidth 4 and 16) against a
// reference model that tracks the LFSR sequence and derives each line from the mode rules.
module tb_gen_line_gap;
  import line_gen_pkg::*;

  localparam int MaxTries = 8;
  localparam int HistLen  = 16384;

  logic        clk;
  logic        rst;
  logic        req1, req2;
  logic [1:0]  mode;
  logic        busy1, busy2, valid1, valid2;
  logic [15:0] line1, line2;
  logic [3:0]  gp1, gp2;

  int vecs  = 0;
  int fails = 0;

  // Model LFSR; hist[k] is the LFSR state the DUT sees just before edge k.
  logic [15:0] m_lfsr = 16'h0001;
  logic [15:0] hist [HistLen];
  int          cyc    = 0;

  gen_line_gap #(
    .Width(16), .GapWidth(4), .BitsPerCycle(4), .LfsrWidth(16), .Seed(16'h0001),
    .MaxTries(MaxTries)
  ) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req1), .mode_i(mode),
    .busy_o(busy1), .valid_o(valid1), .line_o(line1), .gap_pos_o(gp1)
  );

  gen_line_gap #(
    .Width(16), .GapWidth(16), .BitsPerCycle(4), .LfsrWidth(16), .Seed(16'h0001),
    .MaxTries(MaxTries)
  ) dut2 (
    .clk_i(clk), .rst_i(rst), .req_i(req2), .mode_i(mode),
    .busy_o(busy2), .valid_o(valid2), .line_o(line2), .gap_pos_o(gp2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Polynomial x^16+x^14+x^13+x^11+1, right-shifting Galois form.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  always @(posedge clk) begin
    if (cyc < HistLen) hist[cyc] <= m_lfsr;
    m_lfsr <= rst ? 16'h0001 : lfsr_next(m_lfsr);
    cyc    <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line/position/edge offset for a request sampled at edge n.
  task automatic model(input logic [1:0] m, input int n, input int gw,
                       output logic [15:0] line, output int pos, output int off);
    int limit;
    int nd;
    limit = 16 - gw;
    nd    = 0;
    pos   = 0;
    line  = 16'hFFFF;
    if (m[1]) begin
      for (int t = 0; t < MaxTries; t++) begin
        if (int'(hist[n + 1 + t][3:0]) <= limit) begin
          pos = int'(hist[n + 1 + t][3:0]);
          nd  = t + 1;
          break;
        end
        if (t == MaxTries - 1) begin
          pos = limit;
          nd  = t + 1;
        end
      end
    end
    if (m[0]) begin
      for (int k = 0; k < 4; k++) line[4*k +: 4] = hist[n + nd + 1 + k][3:0];
    end
    if (m[1]) begin
      for (int i = 0; i < 16; i++) if (i >= pos && i < pos + gw) line[i] = 1'b0;
    end
    off = (m == MODE_SOLID) ? 0 : nd + (m[0] ? 4 : 0);
  endtask

  // Called at a negedge; returns the request edge index and 1-based cycles to valid.
  task automatic run_req(input bit sel, input logic [1:0] m, output int n, output int lat);
    n    = cyc;
    mode = m;
    if (sel) req2 = 1'b1;
    else     req1 = 1'b1;
    @(negedge clk);
    req1 = 1'b0;
    req2 = 1'b0;
    mode = 2'($urandom);
    lat  = 1;
    while (!(sel ? valid2 : valid1) && lat < 40) begin
      chk("busy_high", 32'(sel ? busy2 : busy1), 1);
      @(negedge clk);
      lat++;
    end
    chk("valid_seen", 32'(sel ? valid2 : valid1), 1);
    chk("busy_low_at_valid", 32'(sel ? busy2 : busy1), 0);
  endtask

  task automatic one(input bit sel, input logic [1:0] m);
    int          n, lat, pos, off, gw;
    logic [15:0] exp_line;
    logic [3:0]  gp;
    gw = sel ? 16 : 4;
    run_req(sel, m, n, lat);
    model(m, n, gw, exp_line, pos, off);
    gp = sel ? gp2 : gp1;
    chk($sformatf("line m%0d w%0d", m, gw), 32'(sel ? line2 : line1), 32'(exp_line));
    chk($sformatf("gap_pos m%0d w%0d", m, gw), 32'(gp), pos);
    chk($sformatf("latency m%0d w%0d", m, gw), lat - 1, off);
    if (m[1]) chk("gap_pos_range", 32'(int'(gp) <= 16 - gw), 1);
  endtask

  initial begin
    int n, j;
    bit acc;
    rst  = 1'b1;
    req1 = 1'b0;
    req2 = 1'b0;
    mode = MODE_SOLID;
    repeat (2) @(negedge clk);
    chk("rst_line", 32'(line1), 32'hFFFF);
    chk("rst_valid", 32'(valid1), 0);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_gap_pos", 32'(gp1), 0);
    chk("rst_line_w16", 32'(line2), 32'hFFFF);
    rst = 1'b0;
    @(negedge clk);

    // SOLID, then confirm valid is a single-cycle pulse.
    one(0, MODE_SOLID);
    @(negedge clk);
    chk("solid_valid_pulse", 32'(valid1), 0);
    chk("solid_busy", 32'(busy1), 0);

    repeat (3) one(0, MODE_NOISE);
    repeat (200) one(0, MODE_GAP);
    repeat (10) one(0, MODE_NOISE_GAP);
    repeat (5) one(1, MODE_GAP);
    repeat (5) one(1, MODE_NOISE_GAP);
    one(1, MODE_NOISE);

    // Mixed traffic on both instances, sometimes back-to-back, sometimes with idle gaps.
    repeat (40) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      one(1'($urandom), 2'($urandom));
    end

    // Abort a NOISE_GAP mid-fill; a request while busy must be dropped.
    @(negedge clk);
    n    = cyc;
    mode = MODE_NOISE_GAP;
    req1 = 1'b1;
    @(negedge clk);
    mode = MODE_SOLID;
    @(negedge clk);
    req1 = 1'b0;
    chk("busy_req_ignored", 32'(valid1), 0);
    j   = 1;
    acc = 1'b0;
    while (!acc) begin
      if (int'(hist[n + j][3:0]) <= 12 || j == MaxTries) begin
        acc = 1'b1;
      end else begin
        j++;
        if (cyc <= n + j) @(negedge clk);
        chk("abort_no_valid_draw", 32'(valid1), 0);
      end
    end
    while (cyc < n + j + 3) @(negedge clk);
    chk("abort_busy_mid_fill", 32'(busy1), 1);
    chk("abort_no_valid_fill", 32'(valid1), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_line", 32'(line1), 32'hFFFF);
    chk("abort_valid", 32'(valid1), 0);
    chk("abort_busy", 32'(busy1), 0);
    chk("abort_gap_pos", 32'(gp1), 0);
    repeat (12) begin
      @(negedge clk);
      chk("abort_no_late_valid", 32'(valid1), 0);
    end
    chk("hist_capacity", 32'(cyc < HistLen), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
